// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus: peripheral requests, mask, core handshake and status outputs.
// The controller connects through the slave modport; the core/peripheral side uses master.
interface interrupt_controller_if #(
    parameter int unsigned NUM_SOURCES = 4
);
    localparam int unsigned ID_W = $clog2(NUM_SOURCES);

    // Requests and control toward the controller
    logic [NUM_SOURCES-1:0] irq_src;
    logic [NUM_SOURCES-1:0] irq_mask;
    logic                   irq_ack;
    logic                   irq_eoi;
    logic                   overflow_clr;

    // Status and request toward the core
    logic                   interrupt;
    logic [ID_W-1:0]        irq_id;
    logic [31:0]            irq_vector;
    logic [NUM_SOURCES-1:0] irq_pending;
    logic [NUM_SOURCES-1:0] irq_overflow;
    logic                   in_service;

    modport master (
        output irq_src,
        output irq_mask,
        output irq_ack,
        output irq_eoi,
        output overflow_clr,
        input  interrupt,
        input  irq_id,
        input  irq_vector,
        input  irq_pending,
        input  irq_overflow,
        input  in_service
    );

    modport slave (
        input  irq_src,
        input  irq_mask,
        input  irq_ack,
        input  irq_eoi,
        input  overflow_clr,
        output interrupt,
        output irq_id,
        output irq_vector,
        output irq_pending,
        output irq_overflow,
        output in_service
    );
endinterface

// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: edge-detects peripheral requests into a pending
// register, picks the lowest-index enabled pending source, and runs an
// assert/ack/service/eoi handshake so only one interrupt is in service at a time.
module interrupt_controller #(
    parameter int unsigned NUM_SOURCES   = 4,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_1000,
    parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0010
) (
    input logic                   clk,
    input logic                   reset,
    interrupt_controller_if.slave bus
);
    localparam int unsigned ID_W = $clog2(NUM_SOURCES);

    typedef enum logic [1:0] {
        StIdle,
        StAssert,
        StService
    } state_e;

    state_e                 r_state;
    state_e                 w_state_next;

    logic [NUM_SOURCES-1:0] r_src_q;
    logic [NUM_SOURCES-1:0] r_pending;
    logic [NUM_SOURCES-1:0] r_overflow;
    logic [ID_W-1:0]        r_id;
    logic [31:0]            r_vector;

    logic [NUM_SOURCES-1:0] w_rise;
    logic [NUM_SOURCES-1:0] w_cand;
    logic [NUM_SOURCES-1:0] w_ack_clr;
    logic [NUM_SOURCES-1:0] w_ovf_set;
    logic [NUM_SOURCES-1:0] w_pending_next;
    logic [NUM_SOURCES-1:0] w_overflow_next;
    logic [ID_W-1:0]        w_win_id;
    logic                   w_win_valid;
    logic [31:0]            w_win_vector;
    logic                   w_load;
    logic                   w_ack_fire;

    assign w_rise = bus.irq_src & ~r_src_q;
    assign w_cand = r_pending & bus.irq_mask;

    // Priority encoder: scan from the top so the lowest set index is the last one written.
    always_comb begin
        w_win_id    = '0;
        w_win_valid = 1'b0;
        for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win_id    = ID_W'(i);
                w_win_valid = 1'b1;
            end
        end
    end

    // Vector arithmetic is modulo 2^32 by construction of the 32-bit result.
    assign w_win_vector = VECTOR_BASE + (32'(w_win_id) * VECTOR_STRIDE);

    // Next-state logic for the handshake FSM; ack beats retraction in ASSERT.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ack_fire   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_win_valid) begin
                    w_state_next = StAssert;
                    w_load       = 1'b1;
                end
            end
            StAssert: begin
                if (bus.irq_ack) begin
                    w_ack_fire   = 1'b1;
                    w_state_next = StService;
                end else if (!bus.irq_mask[r_id]) begin
                    w_state_next = StIdle;
                end
            end
            StService: begin
                if (bus.irq_eoi) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Pending/overflow next values: a new edge beats the ack clear, and an edge on the
    // source being acked in the same cycle is not an overflow.
    always_comb begin
        w_ack_clr       = w_ack_fire ? (NUM_SOURCES'(1) << r_id) : '0;
        w_ovf_set       = w_rise & r_pending & ~w_ack_clr;
        w_pending_next  = (r_pending & ~w_ack_clr) | w_rise;
        w_overflow_next = (bus.overflow_clr ? '0 : r_overflow) | w_ovf_set;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Edge-detect history, pending and sticky overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_q    <= '0;
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_src_q    <= bus.irq_src;
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow_next;
        end
    end

    // Winner ID and vector are captured together when IDLE hands off to ASSERT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id     <= '0;
            r_vector <= VECTOR_BASE;
        end else if (w_load) begin
            r_id     <= w_win_id;
            r_vector <= w_win_vector;
        end
    end

    assign bus.interrupt    = (r_state == StAssert);
    assign bus.in_service   = (r_state == StService);
    assign bus.irq_id       = r_id;
    assign bus.irq_vector   = r_vector;
    assign bus.irq_pending  = r_pending;
    assign bus.irq_overflow = r_overflow;
endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: scoreboard of expected (id, vector) pushed when
// stimulus is driven, popped when the controller presents an interrupt.
module tb_interrupt_controller;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    interrupt_controller_if #(.NUM_SOURCES(4)) ifc ();

    interrupt_controller #(
        .NUM_SOURCES  (4),
        .VECTOR_BASE  (32'h0000_1000),
        .VECTOR_STRIDE(32'h0000_0010)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] vec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] model_vec(input int id);
        return 32'h0000_1000 + 32'(id) * 32'h0000_0010;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = 2'(id);
        e.vec = model_vec(id);
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc.irq_src = '0; ifc.irq_mask = 4'hF; ifc.irq_ack = 1'b0;
        ifc.irq_eoi = 1'b0; ifc.overflow_clr = 1'b0;
        repeat (2) tick();
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL rst_interrupt got=%b exp=0", ifc.interrupt); end
        n_checks++; if (ifc.irq_id !== 2'd0) begin n_errors++; $display("FAIL rst_id got=%0d exp=0", ifc.irq_id); end
        n_checks++; if (ifc.irq_vector !== 32'h1000) begin n_errors++; $display("FAIL rst_vector got=%h exp=1000", ifc.irq_vector); end
        n_checks++; if (ifc.irq_pending !== 4'h0) begin n_errors++; $display("FAIL rst_pending got=%h exp=0", ifc.irq_pending); end
        n_checks++; if (ifc.irq_overflow !== 4'h0) begin n_errors++; $display("FAIL rst_overflow got=%h exp=0", ifc.irq_overflow); end
        n_checks++; if (ifc.in_service !== 1'b0) begin n_errors++; $display("FAIL rst_in_service got=%b exp=0", ifc.in_service); end
        reset = 1'b0;
        tick();
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL rst_idle_interrupt got=%b exp=0", ifc.interrupt); end
    endtask

    task automatic test_single();
        exp_t e;
        push_exp(2);
        ifc.irq_src = 4'b0100;
        tick();
        ifc.irq_src = '0;
        n_checks++; if (ifc.irq_pending !== 4'b0100) begin n_errors++; $display("FAIL t1_pending got=%b exp=0100", ifc.irq_pending); end
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL t1_early_interrupt got=%b exp=0", ifc.interrupt); end
        tick();
        pop_exp(e);
        n_checks++; if (ifc.interrupt !== 1'b1) begin n_errors++; $display("FAIL t1_interrupt got=%b exp=1", ifc.interrupt); end
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t1_id got=%0d exp=%0d", ifc.irq_id, e.id); end
        n_checks++; if (ifc.irq_vector !== e.vec) begin n_errors++; $display("FAIL t1_vector got=%h exp=%h", ifc.irq_vector, e.vec); end
        ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        n_checks++; if (ifc.irq_pending !== 4'b0000) begin n_errors++; $display("FAIL t1_ack_pending got=%b exp=0000", ifc.irq_pending); end
        n_checks++; if (ifc.in_service !== 1'b1) begin n_errors++; $display("FAIL t1_in_service got=%b exp=1", ifc.in_service); end
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL t1_svc_interrupt got=%b exp=0", ifc.interrupt); end
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        n_checks++; if (ifc.in_service !== 1'b0) begin n_errors++; $display("FAIL t1_eoi_in_service got=%b exp=0", ifc.in_service); end
        tick();
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL t1_eoi_interrupt got=%b exp=0", ifc.interrupt); end
    endtask

    task automatic test_priority_back_to_back();
        exp_t e;
        push_exp(1);
        push_exp(3);
        ifc.irq_src = 4'b1010;
        tick();
        ifc.irq_src = '0;
        tick();
        pop_exp(e);
        n_checks++; if (ifc.interrupt !== 1'b1) begin n_errors++; $display("FAIL t2_first_interrupt got=%b exp=1", ifc.interrupt); end
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t2_first_id got=%0d exp=%0d", ifc.irq_id, e.id); end
        ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        // Next winner must appear exactly one cycle after eoi.
        tick();
        pop_exp(e);
        n_checks++; if (ifc.interrupt !== 1'b1) begin n_errors++; $display("FAIL t2_b2b_interrupt got=%b exp=1", ifc.interrupt); end
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t2_second_id got=%0d exp=%0d", ifc.irq_id, e.id); end
        n_checks++; if (ifc.irq_vector !== e.vec) begin n_errors++; $display("FAIL t2_second_vector got=%h exp=%h", ifc.irq_vector, e.vec); end
        ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        n_checks++; if (ifc.irq_pending !== 4'b0000) begin n_errors++; $display("FAIL t2_end_pending got=%b exp=0000", ifc.irq_pending); end
    endtask

    task automatic test_freeze_overflow();
        exp_t e;
        push_exp(2);
        ifc.irq_src = 4'b0100; tick(); ifc.irq_src = '0;
        tick();
        pop_exp(e);
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t3_id got=%0d exp=%0d", ifc.irq_id, e.id); end
        ifc.irq_src = 4'b0001; tick(); ifc.irq_src = '0;
        tick();
        n_checks++; if (ifc.irq_id !== 2'd2) begin n_errors++; $display("FAIL t3_frozen_id got=%0d exp=2", ifc.irq_id); end
        n_checks++; if (ifc.interrupt !== 1'b1) begin n_errors++; $display("FAIL t3_frozen_interrupt got=%b exp=1", ifc.interrupt); end
        n_checks++; if (ifc.irq_pending !== 4'b0101) begin n_errors++; $display("FAIL t3_pending got=%b exp=0101", ifc.irq_pending); end
        ifc.irq_src = 4'b0100; tick(); ifc.irq_src = '0;
        n_checks++; if (ifc.irq_overflow !== 4'b0100) begin n_errors++; $display("FAIL t3_overflow got=%b exp=0100", ifc.irq_overflow); end
        ifc.overflow_clr = 1'b1; tick(); ifc.overflow_clr = 1'b0;
        n_checks++; if (ifc.irq_overflow !== 4'b0000) begin n_errors++; $display("FAIL t3_overflow_clr got=%b exp=0000", ifc.irq_overflow); end
        // New edge on the acked source in the ack cycle: pending stays set, no overflow.
        ifc.irq_ack = 1'b1; ifc.irq_src = 4'b0100; tick(); ifc.irq_ack = 1'b0; ifc.irq_src = '0;
        n_checks++; if (ifc.irq_pending !== 4'b0101) begin n_errors++; $display("FAIL t3_setwins_pending got=%b exp=0101", ifc.irq_pending); end
        n_checks++; if (ifc.irq_overflow !== 4'b0000) begin n_errors++; $display("FAIL t3_setwins_overflow got=%b exp=0000", ifc.irq_overflow); end
        n_checks++; if (ifc.in_service !== 1'b1) begin n_errors++; $display("FAIL t3_in_service got=%b exp=1", ifc.in_service); end
        push_exp(0);
        push_exp(2);
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        tick();
        pop_exp(e);
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t3_id0 got=%0d exp=%0d", ifc.irq_id, e.id); end
        n_checks++; if (ifc.irq_vector !== e.vec) begin n_errors++; $display("FAIL t3_vec0 got=%h exp=%h", ifc.irq_vector, e.vec); end
        ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        tick();
        pop_exp(e);
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t3_id2_again got=%0d exp=%0d", ifc.irq_id, e.id); end
        n_checks++; if (ifc.interrupt !== 1'b1) begin n_errors++; $display("FAIL t3_again_interrupt got=%b exp=1", ifc.interrupt); end
        ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        n_checks++; if (ifc.irq_pending !== 4'b0000) begin n_errors++; $display("FAIL t3_end_pending got=%b exp=0000", ifc.irq_pending); end
    endtask

    task automatic test_mask();
        exp_t e;
        ifc.irq_mask = 4'b1101;
        ifc.irq_src = 4'b0010; tick(); ifc.irq_src = '0;
        tick(); tick();
        n_checks++; if (ifc.irq_pending !== 4'b0010) begin n_errors++; $display("FAIL t4_masked_pending got=%b exp=0010", ifc.irq_pending); end
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL t4_masked_interrupt got=%b exp=0", ifc.interrupt); end
        push_exp(1);
        ifc.irq_mask = 4'hF;
        tick();
        pop_exp(e);
        n_checks++; if (ifc.interrupt !== 1'b1) begin n_errors++; $display("FAIL t4_unmask_interrupt got=%b exp=1", ifc.interrupt); end
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t4_unmask_id got=%0d exp=%0d", ifc.irq_id, e.id); end
        ifc.irq_mask = 4'b1101;
        tick();
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL t4_retract_interrupt got=%b exp=0", ifc.interrupt); end
        n_checks++; if (ifc.irq_pending !== 4'b0010) begin n_errors++; $display("FAIL t4_retract_pending got=%b exp=0010", ifc.irq_pending); end
        n_checks++; if (ifc.in_service !== 1'b0) begin n_errors++; $display("FAIL t4_retract_in_service got=%b exp=0", ifc.in_service); end
        push_exp(1);
        ifc.irq_mask = 4'hF;
        tick();
        pop_exp(e);
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t4_reassert_id got=%0d exp=%0d", ifc.irq_id, e.id); end
        // Mask drop together with ack: ack wins.
        ifc.irq_mask = 4'b1101; ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        n_checks++; if (ifc.in_service !== 1'b1) begin n_errors++; $display("FAIL t4_ackwins_in_service got=%b exp=1", ifc.in_service); end
        n_checks++; if (ifc.irq_pending !== 4'b0000) begin n_errors++; $display("FAIL t4_ackwins_pending got=%b exp=0000", ifc.irq_pending); end
        ifc.irq_mask = 4'hF;
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        n_checks++; if (ifc.in_service !== 1'b0) begin n_errors++; $display("FAIL t4_eoi_in_service got=%b exp=0", ifc.in_service); end
    endtask

    task automatic test_protocol_reset();
        exp_t e;
        ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        n_checks++; if (ifc.in_service !== 1'b0) begin n_errors++; $display("FAIL t5_stray_ack_in_service got=%b exp=0", ifc.in_service); end
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL t5_stray_ack_interrupt got=%b exp=0", ifc.interrupt); end
        push_exp(3);
        ifc.irq_src = 4'b1000; tick(); ifc.irq_src = '0;
        tick();
        pop_exp(e);
        n_checks++; if (ifc.irq_id !== e.id) begin n_errors++; $display("FAIL t5_id got=%0d exp=%0d", ifc.irq_id, e.id); end
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        n_checks++; if (ifc.interrupt !== 1'b1) begin n_errors++; $display("FAIL t5_stray_eoi_interrupt got=%b exp=1", ifc.interrupt); end
        n_checks++; if (ifc.in_service !== 1'b0) begin n_errors++; $display("FAIL t5_stray_eoi_in_service got=%b exp=0", ifc.in_service); end
        ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        ifc.irq_src = 4'b0010; tick(); ifc.irq_src = '0;
        n_checks++; if (ifc.irq_pending !== 4'b0010) begin n_errors++; $display("FAIL t5_svc_accumulate got=%b exp=0010", ifc.irq_pending); end
        n_checks++; if (ifc.in_service !== 1'b1) begin n_errors++; $display("FAIL t5_svc_in_service got=%b exp=1", ifc.in_service); end
        // Asynchronous reset in SERVICE, with src[0] held high across release.
        reset = 1'b1;
        ifc.irq_src = 4'b0001;
        #1;
        n_checks++; if (ifc.in_service !== 1'b0) begin n_errors++; $display("FAIL t5_rst_in_service got=%b exp=0", ifc.in_service); end
        n_checks++; if (ifc.interrupt !== 1'b0) begin n_errors++; $display("FAIL t5_rst_interrupt got=%b exp=0", ifc.interrupt); end
        n_checks++; if (ifc.irq_pending !== 4'b0000) begin n_errors++; $display("FAIL t5_rst_pending got=%b exp=0000", ifc.irq_pending); end
        n_checks++; if (ifc.irq_id !== 2'd0) begin n_errors++; $display("FAIL t5_rst_id got=%0d exp=0", ifc.irq_id); end
        n_checks++; if (ifc.irq_vector !== 32'h1000) begin n_errors++; $display("FAIL t5_rst_vector got=%h exp=1000", ifc.irq_vector); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (ifc.irq_pending !== 4'b0001) begin n_errors++; $display("FAIL t5_held_pending got=%b exp=0001", ifc.irq_pending); end
        push_exp(0);
        tick();
        pop_exp(e);
        n_checks++; if (ifc.interrupt !== 1'b1) begin n_errors++; $display("FAIL t5_held_interrupt got=%b exp=1", ifc.interrupt); end
        n_checks++; if (ifc.irq_vector !== e.vec) begin n_errors++; $display("FAIL t5_held_vector got=%h exp=%h", ifc.irq_vector, e.vec); end
        ifc.irq_src = '0;
        ifc.irq_ack = 1'b1; tick(); ifc.irq_ack = 1'b0;
        ifc.irq_eoi = 1'b1; tick(); ifc.irq_eoi = 1'b0;
        n_checks++; if (ifc.irq_pending !== 4'b0000) begin n_errors++; $display("FAIL t5_end_pending got=%b exp=0000", ifc.irq_pending); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority_back_to_back();
        test_freeze_overflow();
        test_mask();
        test_protocol_reset();
        n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
